// File: rtl/reducer_accumulate_ctrl_if.sv
// reducer_accumulate_ctrl_if: operand-pair input stream and result output stream of the accumulator
//   in_valid/in_ready/in_a/in_b/in_last : operand pairs, producer -> controller
//   out_valid/out_ready/out_sum/out_beats : one result per transaction, controller -> consumer
interface reducer_accumulate_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_beats;
  modport master(output in_valid, in_a, in_b, in_last, out_ready,
                 input in_ready, out_valid, out_sum, out_beats);
  modport slave(input in_valid, in_a, in_b, in_last, out_ready,
                output in_ready, out_valid, out_sum, out_beats);
endinterface

// File: rtl/reducer_accumulate_ctrl.sv
// reducer_accumulate_ctrl: time-shared 4:2 reducer folding operand pairs into a redundant sum, resolved chunkwise
//   clk, rst (async, active-high); bus: slave side of reducer_accumulate_ctrl_if
module reducer_accumulate_ctrl #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  reducer_accumulate_ctrl_if.slave bus
);
  localparam int NCH = ACC_W / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  state_t state;
  logic [ACC_W-1:0] s, c, y, z, s1, c1, t, rsum, rcarry;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] idx;
  logic cy;
  logic [CHUNK:0] part;
  // 4:2 reducer as two carry-save rows; the carry out of the top bit is dropped (mod 2^ACC_W)
  assign y = ACC_W'(bus.in_a);
  assign z = ACC_W'(bus.in_b);
  assign s1 = s ^ c ^ y;
  assign c1 = (s & c) | (s & y) | (c & y);
  assign t = ACC_W'({c1, 1'b0});
  assign rsum = s1 ^ z ^ t;
  assign rcarry = (s1 & z) | (s1 & t) | (z & t);
  assign part = {1'b0, s[idx*CHUNK +: CHUNK]} + {1'b0, c[idx*CHUNK +: CHUNK]} + (CHUNK+1)'(cy);
  assign bus.in_ready = state == ACCUM;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      s <= '0;
      c <= '0;
      cnt <= '0;
      idx <= '0;
      cy <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
      bus.out_beats <= '0;
    end else begin
      case (state)
        ACCUM: if (bus.in_valid) begin
          s <= rsum;
          c <= ACC_W'({rcarry, 1'b0});
          cnt <= cnt + CNT_W'(~&cnt);
          if (bus.in_last) begin
            state <= RESOLVE;
            idx <= '0;
            cy <= 1'b0;
          end
        end
        RESOLVE: begin
          bus.out_sum[idx*CHUNK +: CHUNK] <= part[CHUNK-1:0];
          cy <= part[CHUNK];
          idx <= idx + IW'(1);
          if (idx == IW'(NCH - 1)) begin
            state <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_beats <= cnt;
          end
        end
        DONE: if (bus.out_ready) begin
          state <= ACCUM;
          bus.out_valid <= 1'b0;
          s <= '0;
          c <= '0;
          cnt <= '0;
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
